// File: rtl/serial_tx_framer.sv
// serial_tx_framer: buffers DATA_W-bit flits in a DEPTH-entry FIFO and
// serialises each one as start bit, data, optional parity and stop bits.
// Frames run back-to-back while the FIFO holds data.
module serial_tx_framer #(
  parameter int unsigned DATA_W    = 55,
  parameter int unsigned DEPTH     = 4,
  parameter int unsigned PARITY    = 0,
  parameter int unsigned STOP_BITS = 1,
  parameter int unsigned MSB_FIRST = 0
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [DATA_W-1:0]            TX_Data,
  input  logic                         TX_Valid,
  output logic                         TX_Ready,
  output logic                         S_Data,
  output logic                         Busy,
  output logic [$clog2(DEPTH+1)-1:0]   Level
);

  localparam int unsigned LW = $clog2(DEPTH + 1);
  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = (DATA_W > 1) ? $clog2(DATA_W) : 1;

  localparam logic [CW-1:0] LAST_BIT  = CW'(DATA_W - 1);
  localparam logic [1:0]    LAST_STOP = 2'(STOP_BITS - 1);
  localparam logic [LW-1:0] FULL_LVL  = LW'(DEPTH);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PAR,
    STOP
  } state_t;

  state_t              state;
  state_t              state_nxt;
  logic [DATA_W-1:0]   mem [DEPTH];
  logic [PW-1:0]       wr_ptr;
  logic [PW-1:0]       rd_ptr;
  logic [DATA_W-1:0]   data_q;
  logic [CW-1:0]       bit_cnt;
  logic [CW-1:0]       bit_idx;
  logic [1:0]          stop_cnt;
  logic                push;
  logic                pop;
  logic                s_nxt;

  // FIFO can accept whenever it is not full; Level is 0 during reset so this reads 1
  assign TX_Ready = (Level != FULL_LVL);
  assign push     = TX_Valid && TX_Ready;

  // Frame state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state decode; pop is asserted on every entry into START
  always_comb begin
    state_nxt = state;
    pop       = 1'b0;
    case (state)
      IDLE: begin
        if (Level != '0) begin
          state_nxt = START;
          pop       = 1'b1;
        end
      end
      START: state_nxt = DATA;
      DATA: begin
        if (bit_cnt == LAST_BIT) begin
          state_nxt = (PARITY != 0) ? PAR : STOP;
        end
      end
      PAR: state_nxt = STOP;
      STOP: begin
        if (stop_cnt == LAST_STOP) begin
          if (Level != '0) begin
            state_nxt = START;
            pop       = 1'b1;
          end else begin
            state_nxt = IDLE;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Line value for the current state, registered onto S_Data one cycle later
  always_comb begin
    s_nxt   = 1'b0;
    bit_idx = (MSB_FIRST != 0) ? (LAST_BIT - bit_cnt) : bit_cnt;
    case (state)
      START:   s_nxt = 1'b1;
      DATA:    s_nxt = data_q[bit_idx];
      PAR:     s_nxt = (PARITY == 1) ? ^data_q : ~^data_q;
      default: s_nxt = 1'b0;
    endcase
  end

  // Per-state counters; both clear whenever their state is not active
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bit_cnt  <= '0;
      stop_cnt <= '0;
    end else begin
      bit_cnt  <= (state == DATA) ? bit_cnt + CW'(1) : '0;
      stop_cnt <= (state == STOP) ? stop_cnt + 2'd1 : '0;
    end
  end

  // FIFO pointers, occupancy, and head capture into the frame data register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      Level  <= '0;
      data_q <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PW'(1);
        data_q <= mem[rd_ptr];
      end
      case ({push, pop})
        2'b10:   Level <= Level + LW'(1);
        2'b01:   Level <= Level - LW'(1);
        default: Level <= Level;
      endcase
    end
  end

  // FIFO storage; contents need no reset because the pointers gate visibility
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= TX_Data;
    end
  end

  // Registered line and busy outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      S_Data <= 1'b0;
      Busy   <= 1'b0;
    end else begin
      S_Data <= s_nxt;
      Busy   <= (state != IDLE);
    end
  end

endmodule
